// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the MIPS pipeline hazard unit.
package mips_hazard_pkg;

   // Forwarding mux select encodings for the E-stage ALU operands
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   localparam int unsigned MULT_LAT_DEF = 4;
   localparam int unsigned DIV_LAT_DEF  = 32;
   localparam int unsigned CNT_W        = 6;

   // M-stage result has priority over W-stage; register 0 is never forwarded
   function automatic fwd_sel_e fwd_select(
      input logic [4:0] src,
      input logic       reg_write_m,
      input logic [4:0] write_reg_m,
      input logic       reg_write_w,
      input logic [4:0] write_reg_w
   );
      fwd_sel_e sel;
      sel = FWD_RF;
      if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src))
         sel = FWD_MEM;
      else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy down-counter; MdBusy is high while the count is nonzero.
module md_busy_counter
   import mips_hazard_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic CLK,
   input  logic CLR,
   input  logic MdStartE,
   input  logic MdOpE,
   output logic MdBusy
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign MdBusy = (cnt_q != '0);

   // Next count: load on an accepted issue, otherwise count down to zero.
   // An issue while busy (including the final count==1 cycle) is dropped.
   always_comb begin
      cnt_d = cnt_q;
      if (MdStartE && !MdBusy)
         cnt_d = MdOpE ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (MdBusy)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // Count register with synchronous clear abandoning any in-flight operation
   always_ff @(posedge CLK) begin
      if (CLR)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/mult-div stalls,
// and IF/ID, ID/EX flush control. Only MdBusy is registered.
module hazard_unit
   import mips_hazard_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       JumpD,
   input  logic       BranchTakenD,
   input  logic       MdStartE,
   input  logic       MdOpE,
   input  logic       MdUseD,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       MdBusy
);

   logic lwstall;
   logic branchstall;
   logic mdstall;
   logic stall;
   logic e_hits_d;
   logic m_hits_d;

   md_busy_counter #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_busy_counter (
      .CLK      (CLK),
      .CLR      (CLR),
      .MdStartE (MdStartE),
      .MdOpE    (MdOpE),
      .MdBusy   (MdBusy)
   );

   // Hazard detection, forwarding and flush generation; CLR forces a bubble
   always_comb begin
      e_hits_d    = (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
      m_hits_d    = (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
      lwstall     = MemtoRegE && e_hits_d;
      branchstall = BranchD && ((RegWriteE && e_hits_d) || (MemtoRegM && m_hits_d));
      mdstall     = MdUseD && MdBusy;
      stall       = lwstall || branchstall || mdstall;

      StallF    = stall;
      StallD    = stall;
      FlushE    = stall;
      FlushD    = (BranchTakenD || JumpD) && !stall;
      ForwardAE = fwd_select(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardBE = fwd_select(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardAD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
      ForwardBD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);

      if (CLR) begin
         StallF    = 1'b0;
         StallD    = 1'b0;
         FlushD    = 1'b0;
         FlushE    = 1'b1;
         ForwardAE = FWD_RF;
         ForwardBE = FWD_RF;
         ForwardAD = 1'b0;
         ForwardBD = 1'b0;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;

   logic       CLK = 1'b0;
   logic       CLR;
   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, JumpD, BranchTakenD;
   logic       MdStartE, MdOpE, MdUseD;
   logic       StallF, StallD, FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD;
   logic       MdBusy;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 CLK = ~CLK;

   hazard_unit #(
      .MULT_LAT (4),
      .DIV_LAT  (32)
   ) dut (
      .CLK          (CLK),
      .CLR          (CLR),
      .RsD          (RsD),
      .RtD          (RtD),
      .RsE          (RsE),
      .RtE          (RtE),
      .WriteRegE    (WriteRegE),
      .WriteRegM    (WriteRegM),
      .WriteRegW    (WriteRegW),
      .RegWriteE    (RegWriteE),
      .RegWriteM    (RegWriteM),
      .RegWriteW    (RegWriteW),
      .MemtoRegE    (MemtoRegE),
      .MemtoRegM    (MemtoRegM),
      .BranchD      (BranchD),
      .JumpD        (JumpD),
      .BranchTakenD (BranchTakenD),
      .MdStartE     (MdStartE),
      .MdOpE        (MdOpE),
      .MdUseD       (MdUseD),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .ForwardAD    (ForwardAD),
      .ForwardBD    (ForwardBD),
      .MdBusy       (MdBusy)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
   endtask

   task automatic clear_inputs();
      RsD = '0; RtD = '0; RsE = '0; RtE = '0;
      WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; MemtoRegM = 1'b0;
      BranchD = 1'b0; JumpD = 1'b0; BranchTakenD = 1'b0;
      MdStartE = 1'b0; MdOpE = 1'b0; MdUseD = 1'b0;
   endtask

   // Advance to just after the next rising edge; inputs change here, checks follow #1 later
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      CLR = 1'b1;
      clear_inputs();

      // Reset: hazardous inputs must be masked while CLR is high
      next_cycle();
      RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5;
      MemtoRegE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8; JumpD = 1'b1;
      #1;
      chk("rst_stallf",  {7'd0, StallF},    8'd0);
      chk("rst_flushd",  {7'd0, FlushD},    8'd0);
      chk("rst_flushe",  {7'd0, FlushE},    8'd1);
      chk("rst_fwdae",   {6'd0, ForwardAE}, 8'd0);
      chk("rst_mdbusy",  {7'd0, MdBusy},    8'd0);
      next_cycle();
      CLR = 1'b0;
      clear_inputs();
      #1;
      chk("idle_flushe", {7'd0, FlushE},    8'd0);

      // Forward priority M over W, then W only, then register 0 suppressed
      next_cycle();
      RsE = 5'd5; RtE = 5'd6;
      RegWriteM = 1'b1; WriteRegM = 5'd5;
      RegWriteW = 1'b1; WriteRegW = 5'd5;
      #1;
      chk("fwd_ae_mem",  {6'd0, ForwardAE}, 8'h2);
      chk("fwd_be_rf",   {6'd0, ForwardBE}, 8'h0);
      RegWriteM = 1'b0;
      #1;
      chk("fwd_ae_wb",   {6'd0, ForwardAE}, 8'h1);
      WriteRegM = 5'd0; WriteRegW = 5'd0; RegWriteM = 1'b1; RsE = 5'd0;
      #1;
      chk("fwd_ae_r0",   {6'd0, ForwardAE}, 8'h0);
      RtE = 5'd6; WriteRegW = 5'd6; WriteRegM = 5'd9;
      #1;
      chk("fwd_be_wb",   {6'd0, ForwardBE}, 8'h1);

      // Load-use stall blocks a taken-branch flush
      next_cycle();
      clear_inputs();
      MemtoRegE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8; BranchTakenD = 1'b1;
      #1;
      chk("lw_stallf",   {7'd0, StallF},    8'd1);
      chk("lw_stalld",   {7'd0, StallD},    8'd1);
      chk("lw_flushe",   {7'd0, FlushE},    8'd1);
      chk("lw_flushd",   {7'd0, FlushD},    8'd0);
      WriteRegE = 5'd0; RtD = 5'd0;
      #1;
      chk("lw_r0_stall", {7'd0, StallF},    8'd0);
      chk("lw_r0_flushd",{7'd0, FlushD},    8'd1);

      // Branch hazard: ALU result in E stalls, then forwards from M
      next_cycle();
      clear_inputs();
      BranchD = 1'b1; RsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3;
      #1;
      chk("br_stall",    {7'd0, StallD},    8'd1);
      chk("br_fwdad0",   {7'd0, ForwardAD}, 8'd0);
      next_cycle();
      RegWriteE = 1'b0; WriteRegE = 5'd0;
      RegWriteM = 1'b1; WriteRegM = 5'd3; MemtoRegM = 1'b0;
      #1;
      chk("br_nostall",  {7'd0, StallF},    8'd0);
      chk("br_fwdad1",   {7'd0, ForwardAD}, 8'd1);
      chk("br_fwdbd0",   {7'd0, ForwardBD}, 8'd0);
      MemtoRegM = 1'b1;
      #1;
      chk("br_ldm_stall",{7'd0, StallF},    8'd1);

      // Jump without hazard
      next_cycle();
      clear_inputs();
      JumpD = 1'b1;
      #1;
      chk("jmp_flushd",  {7'd0, FlushD},    8'd1);
      chk("jmp_stallf",  {7'd0, StallF},    8'd0);

      // Divide occupancy with ignored issues at cycle 10 and at the count==1 cycle 32,
      // then a multiply accepted at cycle 33
      next_cycle();
      clear_inputs();
      MdStartE = 1'b1; MdOpE = 1'b1;
      #1;
      chk("div_c0_busy", {7'd0, MdBusy},    8'd0);
      for (int c = 1; c <= 39; c++) begin
         next_cycle();
         MdStartE = 1'b0; MdOpE = 1'b0; MdUseD = 1'b1;
         if (c == 10 || c == 32) begin
            $display("note: protocol error injected, MdStartE while busy at cycle %0d", c);
            MdStartE = 1'b1;
         end
         if (c == 33) MdStartE = 1'b1;
         #1;
         chk($sformatf("md_busy_c%0d", c), {7'd0, MdBusy},
             ((c >= 1 && c <= 32) || (c >= 34 && c <= 37)) ? 8'd1 : 8'd0);
         if (c == 5 || c == 10 || c == 32 || c == 33 || c == 34 || c == 38)
            chk($sformatf("md_stall_c%0d", c), {7'd0, StallF},
                ((c >= 1 && c <= 32) || (c >= 34 && c <= 37)) ? 8'd1 : 8'd0);
      end

      // Reset mid-divide abandons the count
      next_cycle();
      clear_inputs();
      MdStartE = 1'b1; MdOpE = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         MdStartE = 1'b0; MdUseD = 1'b1;
         CLR = (c == 5);
         #1;
         if (c == 5) begin
            chk("rd_c5_busy",   {7'd0, MdBusy}, 8'd1);
            chk("rd_c5_flushe", {7'd0, FlushE}, 8'd1);
            chk("rd_c5_stallf", {7'd0, StallF}, 8'd0);
         end else begin
            chk($sformatf("rd_busy_c%0d", c), {7'd0, MdBusy}, (c < 5) ? 8'd1 : 8'd0);
            chk($sformatf("rd_stall_c%0d", c), {7'd0, StallF}, (c < 5) ? 8'd1 : 8'd0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
